priority_encoder_stream: RTL and testbench



---
 rtl/priority_encoder_stream_pkg.sv | 26 ++
 rtl/lsb_index_find.sv | 28 ++
 rtl/priority_encoder_stream.sv | 105 ++++++++++
 tb/tb_priority_encoder_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_stream_pkg.sv
// Shared types and bit-manipulation helpers for priority_encoder_stream.
//   state_t     : serialiser state (IDLE, SCAN)
//   onehot_lsb  : isolates the lowest set bit of a vector
//   is_single   : true when exactly one bit of a vector is set
// The helpers work on MAX_WIDTH bits. Callers zero-extend narrower vectors,
// which leaves both results unchanged.
package priority_encoder_stream_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    function automatic logic [MAX_WIDTH-1:0] onehot_lsb(input logic [MAX_WIDTH-1:0] vec);
        return vec & (~vec + 64'd1);
    endfunction

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    function automatic logic is_single(input logic [MAX_WIDTH-1:0] vec);
        return (vec != '0) && ((vec & (vec - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/lsb_index_find.sv
// Combinational lowest-set-bit encoder.
// This is the WIDTH-parametrised form of the old fixed 5-bit priority encoder.
// Ports:
//   vec : input vector
//   idx : index of the lowest set bit of vec; 0 when vec is zero
//   any : vec has at least one bit set
module lsb_index_find #(
    parameter int WIDTH = 5,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so that the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder.
// The block accepts a WIDTH-bit hot vector on a valid/ready handshake. It then
// emits the index of each set bit, lowest first, one per cycle, on a
// valid/ready stream. An all-zero vector is consumed and produces no output.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   flush_i           : drop the vector in progress and return to IDLE
//   vec_valid_i/vec_ready_o/hot_vector_i : input vector handshake
//   idx_valid_o/idx_ready_i/idx_o        : output index stream
//   busy_o            : a vector is being serialised
//   last_o            : present only when PRIORITY_ENCODER_STREAM_LAST_EN is
//                       defined; marks the final index of each vector
// Timing note: vec_ready_o depends combinationally on idx_ready_i. This lets
// the next vector load on the same cycle that the final index is taken.
module priority_encoder_stream
    import priority_encoder_stream_pkg::*;
#(
    parameter int WIDTH = 5,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [WIDTH-1:0] hot_vector_i,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             busy_o
`ifdef PRIORITY_ENCODER_STREAM_LAST_EN
    ,
    output logic             last_o
`endif
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic [WIDTH-1:0] pend_cleared;
    logic [IDX_W-1:0] lsb_idx;
    logic             lsb_any;
    logic             pend_single;
    logic             accept;

    lsb_index_find #(.WIDTH(WIDTH)) u_lsb_index_find (
        .vec (pend_reg),
        .idx (lsb_idx),
        .any (lsb_any)
    );

    assign pend_single  = is_single(64'(pend_reg));
    assign pend_cleared = WIDTH'(64'(pend_reg) & ~onehot_lsb(64'(pend_reg)));

    assign vec_ready_o = !reset && !flush_i &&
                         (state_reg == IDLE ||
                          (state_reg == SCAN && idx_ready_i && pend_single));
    assign accept      = vec_valid_i && vec_ready_o;

    // Reset gates the outputs straight away, before the state register clears.
    assign idx_valid_o = (state_reg == SCAN) && !reset;
    assign idx_o       = (idx_valid_o && lsb_any) ? lsb_idx : '0;
    assign busy_o      = idx_valid_o;

`ifdef PRIORITY_ENCODER_STREAM_LAST_EN
    assign last_o = idx_valid_o && pend_single;
`endif

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        if (flush_i) begin
            state_next = IDLE;
            pend_next  = '0;
        end else begin
            if (state_reg == SCAN && idx_ready_i) begin
                pend_next = pend_cleared;
                if (pend_cleared == '0) begin
                    state_next = IDLE;
                end
            end
            // A new vector can only arrive once the current one is on its
            // final beat, so it safely overrides the clear above.
            if (accept) begin
                if (hot_vector_i != '0) begin
                    pend_next  = hot_vector_i;
                    state_next = SCAN;
                end else begin
                    pend_next  = '0;
                    state_next = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
        end
    end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Testbench for priority_encoder_stream, WIDTH=6 (a width that is not a power
// of two, so the maximum index is 5).
// The reference model keeps a queue of the indices still owed. Every
// negative clock edge, the DUT outputs are compared with what that queue
// implies. Directed tests pin the model with hand-computed sequences.
module tb_priority_encoder_stream;

    localparam int WIDTH = 6;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk;
    logic             reset;
    logic             flush_i;
    logic             vec_valid_i;
    logic             vec_ready_o;
    logic [WIDTH-1:0] hot_vector_i;
    logic             idx_valid_o;
    logic             idx_ready_i;
    logic [IDX_W-1:0] idx_o;
    logic             busy_o;
`ifdef PRIORITY_ENCODER_STREAM_LAST_EN
    logic             last_o;
`endif

    priority_encoder_stream #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .vec_valid_i  (vec_valid_i),
        .vec_ready_o  (vec_ready_o),
        .hot_vector_i (hot_vector_i),
        .idx_valid_o  (idx_valid_o),
        .idx_ready_i  (idx_ready_i),
        .idx_o        (idx_o),
        .busy_o       (busy_o)
`ifdef PRIORITY_ENCODER_STREAM_LAST_EN
        ,
        .last_o       (last_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: indices owed, lowest first.
    int q[$];

    function automatic bit model_ready();
        return !reset && !flush_i && (q.size() == 0 || (idx_ready_i && q.size() == 1));
    endfunction

    always @(posedge clk) begin
        bit r;
        r = model_ready();
        if (reset || flush_i) begin
            q.delete();
        end else begin
            if (q.size() > 0 && idx_ready_i) void'(q.pop_front());
            if (vec_valid_i && r) begin
                $display("accept vec=%b", hot_vector_i);
                for (int i = 0; i < WIDTH; i++)
                    if (hot_vector_i[i]) q.push_back(i);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit ev;
        ev = !reset && q.size() > 0;
        chk("idx_valid", int'(idx_valid_o), int'(ev));
        chk("idx", int'(idx_o), ev ? q[0] : 0);
        chk("busy", int'(busy_o), int'(ev));
        chk("vec_ready", int'(vec_ready_o), int'(model_ready()));
`ifdef PRIORITY_ENCODER_STREAM_LAST_EN
        chk("last", int'(last_o), int'(ev && q.size() == 1));
`endif
    end

    // Log of delivered indices, one nibble per beat.
    int got_code = 0;
    int got_n    = 0;
    always @(negedge clk) begin
        if (idx_valid_o && idx_ready_i) begin
            $display("beat idx=%0d", idx_o);
            got_code = (got_code << 4) | int'(idx_o);
            got_n++;
        end
    end

    task automatic got_clear();
        got_code = 0;
        got_n    = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold it until it is accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] v);
        bit done;
        done = 0;
        vec_valid_i  = 1'b1;
        hot_vector_i = v;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (vec_ready_o) begin
                step();
                done = 1;
            end
        end
        vec_valid_i = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!idx_valid_o) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        reset        = 1'b1;
        flush_i      = 1'b0;
        vec_valid_i  = 1'b0;
        hot_vector_i = '0;
        idx_ready_i  = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_valid", int'(idx_valid_o), 0);
        chk("rst_ready", int'(vec_ready_o), 0);
        step();
        reset = 1'b0;

        // 010110 -> 1,2,4, with the first index one cycle after accept
        got_clear();
        send(6'b010110);
        @(negedge clk);
        chk("t1_first_valid", int'(idx_valid_o), 1);
        chk("t1_first_idx", int'(idx_o), 1);
        wait_idle();
        chk("t1_ready_after", int'(vec_ready_o), 1);
        chk("t1_seq", got_code, 'h124);
        chk("t1_n", got_n, 3);

        // zero vector: consumed, no output
        step();
        got_clear();
        send(6'b000000);
        @(negedge clk);
        chk("t2_valid", int'(idx_valid_o), 0);
        chk("t2_ready", int'(vec_ready_o), 1);
        chk("t2_n", got_n, 0);

        // 100001 with a 3-cycle stall: index 0 held, then 0 and 5
        step();
        got_clear();
        idx_ready_i = 1'b0;
        send(6'b100001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", int'(idx_valid_o), 1);
            chk("t3_hold_idx", int'(idx_o), 0);
        end
        step();
        idx_ready_i = 1'b1;
        wait_idle();
        chk("t3_seq", got_code, 'h05);
        chk("t3_n", got_n, 2);

        // back-to-back 000001 and 001100 -> 0,2,3 with no bubble
        step();
        got_clear();
        send(6'b000001);
        send(6'b001100);
        wait_idle();
        chk("t4_seq", got_code, 'h023);
        chk("t4_n", got_n, 3);

        // 011111, flush during the second beat -> 0,1; then 001000 -> 3
        step();
        got_clear();
        send(6'b011111);
        @(negedge clk);
        step();
        flush_i = 1'b1;
        @(negedge clk);
        chk("t5_flush_ready", int'(vec_ready_o), 0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("t5_idle_valid", int'(idx_valid_o), 0);
        chk("t5_flush_seq", got_code, 'h01);
        step();
        send(6'b001000);
        wait_idle();
        chk("t5_seq", got_code, 'h013);
        chk("t5_n", got_n, 3);

        // 100000, reset while index 5 is pending: it is never delivered
        step();
        got_clear();
        idx_ready_i = 1'b0;
        send(6'b100000);
        @(negedge clk);
        chk("t6_pre_idx", int'(idx_o), 5);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", int'(idx_valid_o), 0);
        chk("t6_rst_idx", int'(idx_o), 0);
        chk("t6_rst_busy", int'(busy_o), 0);
        step();
        reset       = 1'b0;
        idx_ready_i = 1'b1;
        @(negedge clk);
        chk("t6_post_valid", int'(idx_valid_o), 0);
        chk("t6_n", got_n, 0);

        // all ones: every index up to WIDTH-1
        step();
        got_clear();
        send(6'b111111);
        wait_idle();
        chk("t7_seq", got_code, 'h012345);
        chk("t7_n", got_n, 6);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
